// File: rtl/mips_cpu_load_store_unit.sv
// -----------------------------------------------------------------------------
// mips_cpu_load_store_unit
//
// Memory-access stage of the MIPS CPU. Accepts one load/store per request,
// checks alignment, drives one Avalon-style bus transfer (word address,
// byteenable, lane-shifted write data including swl/swr), waits out
// waitrequest and returns the raw memory word for loads. Lane extraction and
// sign extension happen downstream in the register file.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   i_req_valid          datapath presents a memory instruction
//   o_req_ready          high only while idle; accept on valid && ready
//   i_req_opcode[5:0]    MIPS opcode
//   i_req_addr[31:0]     effective byte address
//   i_req_storedata      rt value for stores (ignored for loads)
//   o_resp_valid         one-cycle completion pulse
//   o_resp_loaddata      raw memory word for loads, 0 for stores/faults
//   o_resp_addr_lo[1:0]  low address bits of the completed request
//   o_resp_fault         misaligned or non-memory opcode (no bus cycle)
//   o_address            bus word address
//   o_read, o_write      bus strobes (registered, mutually exclusive)
//   o_byteenable[3:0]    bus lane enables, bit n = data bits [8n+7:8n]
//   o_writedata          bus write data
//   i_waitrequest        bus stall
//   i_readdata           bus read data, valid on the completing edge
// -----------------------------------------------------------------------------
module mips_cpu_load_store_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [5:0]  i_req_opcode,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_storedata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_loaddata,
    output logic [1:0]  o_resp_addr_lo,
    output logic        o_resp_fault,
    output logic [31:0] o_address,
    output logic        o_read,
    output logic        o_write,
    output logic [3:0]  o_byteenable,
    output logic [31:0] o_writedata,
    input  logic        i_waitrequest,
    input  logic [31:0] i_readdata
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SWL = 6'b101010;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SWR = 6'b101110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_read;
    logic        r_write;
    logic [31:0] r_address;
    logic [3:0]  r_byteenable;
    logic [31:0] r_writedata;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_resp_loaddata;
    logic [1:0]  r_resp_addr_lo;
    logic        r_resp_fault;

    logic [1:0]  w_a;
    logic [1:0]  w_inv_a;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_misaligned;
    logic        w_fault;
    logic [3:0]  w_be;
    logic [31:0] w_wd;

    // Request decode: classify the opcode and form the bus lanes straight
    // from the request inputs so they can be registered on the accept edge.
    always_comb begin
        w_a          = i_req_addr[1:0];
        w_inv_a      = 2'd3 - w_a;
        w_is_load    = 1'b0;
        w_is_store   = 1'b0;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wd         = 32'd0;
        case (i_req_opcode)
            OP_LB, OP_LBU, OP_LWL, OP_LWR: begin
                w_is_load = 1'b1;
            end
            OP_LH, OP_LHU: begin
                w_is_load    = 1'b1;
                w_misaligned = w_a[0];
            end
            OP_LW: begin
                w_is_load    = 1'b1;
                w_misaligned = (w_a != 2'd0);
            end
            OP_SB: begin
                w_is_store = 1'b1;
                w_be       = 4'b0001 << w_a;
                w_wd       = {4{i_req_storedata[7:0]}};
            end
            OP_SH: begin
                w_is_store   = 1'b1;
                w_misaligned = w_a[0];
                w_be         = w_a[1] ? 4'b1100 : 4'b0011;
                w_wd         = {2{i_req_storedata[15:0]}};
            end
            OP_SW: begin
                w_is_store   = 1'b1;
                w_misaligned = (w_a != 2'd0);
                w_wd         = i_req_storedata;
            end
            // swl writes the top (a+1) bytes of rt into lanes a..0.
            OP_SWL: begin
                w_is_store = 1'b1;
                w_be       = 4'b1111 >> w_inv_a;
                w_wd       = i_req_storedata >> {w_inv_a, 3'b000};
            end
            // swr writes the low (4-a) bytes of rt into lanes a..3.
            OP_SWR: begin
                w_is_store = 1'b1;
                w_be       = 4'b1111 << w_a;
                w_wd       = i_req_storedata << {w_a, 3'b000};
            end
            default: ;
        endcase
        w_fault = !(w_is_load || w_is_store) || w_misaligned;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        w_state_next = r_state;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (w_fault)        w_state_next = S_RESP;
                    else if (w_is_load) w_state_next = S_READ;
                    else                w_state_next = S_WRITE;
                end
            end
            S_READ, S_WRITE: begin
                if (!i_waitrequest) w_state_next = S_RESP;
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bus and response registers. Bus outputs change only on accept and on
    // completion, so they stay stable across waitrequest. Response fields are
    // written only when entering RESP and hold until the next response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_read          <= 1'b0;
            r_write         <= 1'b0;
            r_address       <= 32'd0;
            r_byteenable    <= 4'd0;
            r_writedata     <= 32'd0;
            r_addr_lo       <= 2'd0;
            r_resp_loaddata <= 32'd0;
            r_resp_addr_lo  <= 2'd0;
            r_resp_fault    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        if (w_fault) begin
                            r_resp_fault    <= 1'b1;
                            r_resp_loaddata <= 32'd0;
                            r_resp_addr_lo  <= i_req_addr[1:0];
                        end else begin
                            r_read       <= w_is_load;
                            r_write      <= w_is_store;
                            r_address    <= {i_req_addr[31:2], 2'b00};
                            r_byteenable <= w_be;
                            r_writedata  <= w_wd;
                            r_addr_lo    <= i_req_addr[1:0];
                        end
                    end
                end
                S_READ: begin
                    if (!i_waitrequest) begin
                        r_read          <= 1'b0;
                        r_resp_loaddata <= i_readdata;
                        r_resp_addr_lo  <= r_addr_lo;
                        r_resp_fault    <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (!i_waitrequest) begin
                        r_write         <= 1'b0;
                        r_resp_loaddata <= 32'd0;
                        r_resp_addr_lo  <= r_addr_lo;
                        r_resp_fault    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_read          = r_read;
    assign o_write         = r_write;
    assign o_address       = r_address;
    assign o_byteenable    = r_byteenable;
    assign o_writedata     = r_writedata;
    assign o_resp_loaddata = r_resp_loaddata;
    assign o_resp_addr_lo  = r_resp_addr_lo;
    assign o_resp_fault    = r_resp_fault;

endmodule

// File: tb/tb_mips_cpu_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_load_store_unit
//
// Scoreboarded bench for the load/store unit. The driver computes the expected
// bus transfer and response from MIPS byte-store semantics and pushes it into
// a queue; a monitor pops and compares when the DUT presents a bus strobe or a
// response. A bus responder applies per-request wait counts and returns words
// from a small memory model.
// -----------------------------------------------------------------------------
module tb_mips_cpu_load_store_unit;

    localparam logic [5:0] LB  = 6'b100000, LH  = 6'b100001, LWL = 6'b100010;
    localparam logic [5:0] LW  = 6'b100011, LBU = 6'b100100, LHU = 6'b100101;
    localparam logic [5:0] LWR = 6'b100110, SB  = 6'b101000, SH  = 6'b101001;
    localparam logic [5:0] SWL = 6'b101010, SW  = 6'b101011, SWR = 6'b101110;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [5:0]  i_req_opcode;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_storedata;
    logic        o_resp_valid;
    logic [31:0] o_resp_loaddata;
    logic [1:0]  o_resp_addr_lo;
    logic        o_resp_fault;
    logic [31:0] o_address;
    logic        o_read;
    logic        o_write;
    logic [3:0]  o_byteenable;
    logic [31:0] o_writedata;
    logic        i_waitrequest;
    logic [31:0] i_readdata;

    mips_cpu_load_store_unit dut (
        .clk             (clk),
        .resetn          (resetn),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_opcode    (i_req_opcode),
        .i_req_addr      (i_req_addr),
        .i_req_storedata (i_req_storedata),
        .o_resp_valid    (o_resp_valid),
        .o_resp_loaddata (o_resp_loaddata),
        .o_resp_addr_lo  (o_resp_addr_lo),
        .o_resp_fault    (o_resp_fault),
        .o_address       (o_address),
        .o_read          (o_read),
        .o_write         (o_write),
        .o_byteenable    (o_byteenable),
        .o_writedata     (o_writedata),
        .i_waitrequest   (i_waitrequest),
        .i_readdata      (i_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        is_fault;
        logic        is_load;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
        logic [1:0]  lo;
        int          acc;
        int          waits;
    } exp_t;

    exp_t        exp_q[$];
    int          wait_q[$];
    logic [31:0] mem_init [logic [31:0]];

    int n_cmp = 0;
    int n_err = 0;
    int n_issued = 0;
    int n_resp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Memory contents: a few preset words, everything else a fixed hash.
    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        if (mem_init.exists(wa)) return mem_init[wa];
        return {wa[15:0] ^ 16'h5A3C, wa[31:16] ^ 16'hC3A5};
    endfunction

    function automatic logic [7:0] rt_byte(input logic [31:0] rt, input int k);
        return 8'((rt >> (8 * k)) & 32'hFF);
    endfunction

    // Reference model: access size decides alignment; each store is described
    // by which byte addresses of the word it writes and with which byte of rt.
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt);
        exp_t e;
        int   size;
        bit   known;
        bit   is_ld;
        int   lo;
        e     = '0;
        lo    = int'(a[1:0]);
        known = 1'b1;
        is_ld = (op == LB || op == LH || op == LWL || op == LW ||
                 op == LBU || op == LHU || op == LWR);
        if (op == LB || op == LBU || op == SB)       size = 1;
        else if (op == LH || op == LHU || op == SH)  size = 2;
        else if (op == LW || op == SW)               size = 4;
        else if (op == LWL || op == LWR || op == SWL || op == SWR) size = 1;
        else begin
            size  = 1;
            known = 1'b0;
        end
        e.lo = a[1:0];
        if (!known || (lo % size) != 0) begin
            e.is_fault = 1'b1;
            return e;
        end
        e.addr = a & 32'hFFFF_FFFC;
        if (is_ld) begin
            e.is_load = 1'b1;
            e.be      = 4'hF;
            e.wd      = 32'd0;
            e.ld      = mem_word(e.addr);
            return e;
        end
        if (op == SB)      e.wd = {4{rt[7:0]}};
        else if (op == SH) e.wd = {2{rt[15:0]}};
        for (int b = 0; b < 4; b++) begin
            bit       en;
            logic [7:0] v;
            en = 1'b0;
            v  = 8'd0;
            if (op == SB && b == lo)                   begin en = 1; v = rt_byte(rt, 0); end
            if (op == SH && (b == lo || b == lo + 1))  begin en = 1; v = rt_byte(rt, b - lo); end
            if (op == SW)                              begin en = 1; v = rt_byte(rt, b); end
            if (op == SWL && b <= lo)                  begin en = 1; v = rt_byte(rt, 3 - (lo - b)); end
            if (op == SWR && b >= lo)                  begin en = 1; v = rt_byte(rt, b - lo); end
            if (en) begin
                e.be[b]        = 1'b1;
                e.wd[8*b +: 8] = v;
            end
        end
        return e;
    endfunction

    // ---------------- bus responder ----------------
    int  resp_rem = 0;
    bit  resp_busy = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            resp_rem      = 0;
            resp_busy     = 0;
            i_waitrequest = 1'b0;
            wait_q.delete();
        end else if (o_read || o_write) begin
            if (!resp_busy) begin
                resp_busy = 1;
                resp_rem  = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
            end
            if (resp_rem > 0) begin
                i_waitrequest = 1'b1;
                i_readdata    = $urandom;
                resp_rem--;
            end else begin
                i_waitrequest = 1'b0;
                i_readdata    = mem_word(o_address);
            end
        end else begin
            resp_busy     = 0;
            i_waitrequest = 1'($urandom_range(0, 1));
            i_readdata    = $urandom;
        end
    end

    // ---------------- monitor ----------------
    exp_t cur;
    bit   have_cur = 0;
    bit   in_xfer = 0;
    int   n_strobe = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            have_cur = 0;
            in_xfer  = 0;
        end else begin
            if (o_read || o_write) check("rw_exclusive", {31'd0, o_read & o_write}, 32'd0);
            if (in_xfer) begin
                if (o_read || o_write) begin
                    n_strobe++;
                    check("hold_read", {31'd0, o_read}, {31'd0, cur.is_load});
                    check("hold_write", {31'd0, o_write}, {31'd0, !cur.is_load});
                    check("hold_addr", o_address, cur.addr);
                    check("hold_be", {28'd0, o_byteenable}, {28'd0, cur.be});
                    check("hold_wd", o_writedata, cur.wd);
                end else begin
                    check("strobe_cycles", n_strobe, cur.waits + 1);
                    in_xfer = 0;
                end
            end else if (o_read || o_write) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {30'd0, o_read, o_write}, 32'd0);
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1;
                    in_xfer  = 1;
                    n_strobe = 1;
                    if (cur.is_fault)
                        check("bus_on_fault", {30'd0, o_read, o_write}, 32'd0);
                    check("bus_read", {31'd0, o_read}, {31'd0, cur.is_load});
                    check("bus_write", {31'd0, o_write}, {31'd0, !cur.is_load});
                    check("bus_addr", o_address, cur.addr);
                    check("bus_be", {28'd0, o_byteenable}, {28'd0, cur.be});
                    check("bus_wd", o_writedata, cur.wd);
                    check("strobe_start", cyc, cur.acc);
                end
            end
            if (o_resp_valid) begin
                n_resp++;
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", {31'd0, o_resp_valid}, 32'd0);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1;
                    end
                end
                if (have_cur) begin
                    check("resp_fault", {31'd0, o_resp_fault}, {31'd0, cur.is_fault});
                    check("resp_loaddata", o_resp_loaddata, cur.ld);
                    check("resp_addr_lo", {30'd0, o_resp_addr_lo}, {30'd0, cur.lo});
                    check("resp_cycle", cyc, cur.is_fault ? cur.acc : cur.acc + 1 + cur.waits);
                    $display("[%0d] resp fault=%0d addr_lo=%0d data=%08h", cyc, o_resp_fault,
                             o_resp_addr_lo, o_resp_loaddata);
                end
                have_cur = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                         input int waits, input bit junk);
        exp_t e;
        @(posedge clk); #1;
        e       = model(op, a, rt);
        e.acc   = cyc + 1;
        e.waits = waits;
        exp_q.push_back(e);
        if (!e.is_fault) wait_q.push_back(waits);
        n_issued++;
        i_req_valid     = 1'b1;
        i_req_opcode    = op;
        i_req_addr      = a;
        i_req_storedata = rt;
        @(posedge clk); #1;
        if (junk) begin
            // Still asserted while busy: must be ignored.
            i_req_opcode    = 6'($urandom);
            i_req_addr      = $urandom;
            i_req_storedata = $urandom;
            @(posedge clk); #1;
        end
        i_req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (n_resp < n_issued && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (n_resp < n_issued) begin
            check("resp_timeout", n_resp, n_issued);
            n_resp = n_issued;
            exp_q.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {31'd0, o_req_ready}, 32'd1);
        check({tag, "_read"}, {31'd0, o_read}, 32'd0);
        check({tag, "_write"}, {31'd0, o_write}, 32'd0);
        check({tag, "_resp_valid"}, {31'd0, o_resp_valid}, 32'd0);
        check({tag, "_resp_fault"}, {31'd0, o_resp_fault}, 32'd0);
        check({tag, "_address"}, o_address, 32'd0);
        check({tag, "_be"}, {28'd0, o_byteenable}, 32'd0);
        check({tag, "_wd"}, o_writedata, 32'd0);
        check({tag, "_loaddata"}, o_resp_loaddata, 32'd0);
        check({tag, "_addr_lo"}, {30'd0, o_resp_addr_lo}, 32'd0);
    endtask

    logic [5:0] ops [12] = '{LB, LH, LWL, LW, LBU, LHU, LWR, SB, SH, SWL, SW, SWR};

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        mem_init[32'h0000_1000] = 32'hDEAD_BEEF;
        mem_init[32'h0000_0600] = 32'h1357_9BDF;
        resetn          = 1'b0;
        i_req_valid     = 1'b0;
        i_req_opcode    = 6'd0;
        i_req_addr      = 32'd0;
        i_req_storedata = 32'd0;
        i_waitrequest   = 1'b0;
        i_readdata      = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        // Directed cases.
        issue(LW, 32'h0000_1000, 32'h0, 0, 0);              wait_done();
        issue(SB, 32'h0000_2003, 32'h1234_5678, 0, 0);      wait_done();
        for (int i = 0; i < 4; i++) begin
            issue(SWL, 32'h0000_0500 + i, 32'hAABB_CCDD, 0, 0); wait_done();
        end
        for (int i = 0; i < 4; i++) begin
            issue(SWR, 32'h0000_0500 + i, 32'hAABB_CCDD, 0, 0); wait_done();
        end
        issue(LH, 32'h0000_0040, 32'h0, 3, 0);              wait_done();
        issue(LW, 32'h0000_1002, 32'h0, 0, 0);              wait_done();
        issue(6'b000000, 32'h0000_0000, 32'h0, 0, 1);       wait_done();

        // Reset in the middle of a stalled store.
        issue(LWL, 32'h0000_0603, 32'h0, 0, 0);             wait_done();
        issue(SW, 32'h0000_0300, 32'hCAFE_F00D, 8, 0);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        n_resp = n_issued;
        exp_q.delete();
        wait_q.delete();
        @(negedge clk);
        check_reset_values("midreset");
        repeat (4) @(negedge clk);

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            issue(op, a, $urandom, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
            wait_done();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
